stroke_interp: RTL and testbench

Line-interpolation stage between `user_input2` and `frame_buffer`. It takes the cursor point sampled once per frame and emits every canvas pixel on the straight segment from the previous point to the new one, one pixel per cycle, using Bresenham stepping. Fast cursor motion therefore draws a continuous stroke instead of dots spaced one frame apart. It runs in the `clk_pixel` domain on the 640x360 scaled canvas.

---
 rtl/stroke_pkg.sv | 25 ++
 rtl/line_stepper.sv | 45 ++++
 rtl/stroke_interp.sv | 196 +++++++++++++++++++
 tb/tb_stroke_interp.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stroke_pkg.sv
// Shared types and constants for the stroke interpolation stage: FSM states,
// canvas geometry, coordinate types and the signed arithmetic used for stepping.
package stroke_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STEP
    } stroke_state_t;

    localparam int CANVAS_W = 640;
    localparam int CANVAS_H = 360;

    typedef logic [9:0] canvas_x_t;
    typedef logic [8:0] canvas_y_t;

    // 12 signed bits cover every delta and error term of a 640x360 canvas.
    localparam int CALC_W = 12;
    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic calc_t abs_calc(input calc_t v);
        return v[CALC_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/line_stepper.sv
// Combinational Bresenham step: next (x, y, err) from the current position,
// the error term and the fixed segment parameters.
module line_stepper
    import stroke_pkg::*;
#(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9
) (
    input  logic [X_WIDTH-1:0] x_i,
    input  logic [Y_WIDTH-1:0] y_i,
    input  calc_t              err_i,
    input  calc_t              dx_i,
    input  calc_t              dy_i,
    input  logic               sx_neg_i,
    input  logic               sy_neg_i,
    output logic [X_WIDTH-1:0] x_o,
    output logic [Y_WIDTH-1:0] y_o,
    output calc_t              err_o
);

    calc_t e2;
    calc_t x_ext;
    calc_t y_ext;
    calc_t err_acc;

    always_comb begin
        e2      = err_i <<< 1;
        x_ext   = calc_t'(x_i);
        y_ext   = calc_t'(y_i);
        err_acc = err_i;
        // Both tests use the pre-update error, so e2 is computed once up front.
        if (e2 >= dy_i) begin
            err_acc = err_acc + dy_i;
            x_ext   = sx_neg_i ? x_ext - calc_t'(1) : x_ext + calc_t'(1);
        end
        if (e2 <= dx_i) begin
            err_acc = err_acc + dx_i;
            y_ext   = sy_neg_i ? y_ext - calc_t'(1) : y_ext + calc_t'(1);
        end
        x_o   = X_WIDTH'(x_ext);
        y_o   = Y_WIDTH'(y_ext);
        err_o = err_acc;
    end

endmodule

// File: rtl/stroke_interp.sv
// Turns per-frame cursor points into a continuous pixel stroke: one Bresenham
// pixel per cycle from the previous anchor to the new point.
module stroke_interp
    import stroke_pkg::*;
#(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9,
    parameter int MAX_X   = CANVAS_W - 1,
    parameter int MAX_Y   = CANVAS_H - 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               pt_valid_in,
    output logic               pt_ready_out,
    input  logic [X_WIDTH-1:0] x_in,
    input  logic [Y_WIDTH-1:0] y_in,
    input  logic [3:0]         color_in,
    input  logic [2:0]         sw_in,
    input  logic               pen_down_in,
    output logic               px_valid_out,
    input  logic               px_ready_in,
    output logic [X_WIDTH-1:0] px_x_out,
    output logic [Y_WIDTH-1:0] px_y_out,
    output logic [3:0]         px_color_out,
    output logic [2:0]         px_sw_out,
    output logic               seg_done_out
);

    localparam logic [X_WIDTH-1:0] MAX_X_C = X_WIDTH'(MAX_X);
    localparam logic [Y_WIDTH-1:0] MAX_Y_C = Y_WIDTH'(MAX_Y);

    stroke_state_t      state_q, state_d;
    logic [X_WIDTH-1:0] anchor_x_q, anchor_x_d, x0_q, x0_d, x1_q, x1_d, px_x_q, px_x_d;
    logic [Y_WIDTH-1:0] anchor_y_q, anchor_y_d, y0_q, y0_d, y1_q, y1_d, px_y_q, px_y_d;
    logic               anchor_valid_q, anchor_valid_d;
    calc_t              dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic               px_valid_q, px_valid_d, seg_done_q, seg_done_d;
    logic [3:0]         color_q, color_d;
    logic [2:0]         sw_q, sw_d;

    logic               accept;
    logic               px_fire;
    logic               at_end;
    logic [X_WIDTH-1:0] x_clamp, step_x;
    logic [Y_WIDTH-1:0] y_clamp, step_y;
    calc_t              step_err, x_diff, y_diff, dx_abs, dy_neg;

    assign pt_ready_out = (state_q == IDLE);
    assign accept       = pt_valid_in && pt_ready_out;
    assign px_fire      = px_valid_q && px_ready_in;
    assign at_end       = (px_x_q == x1_q) && (px_y_q == y1_q);
    assign x_clamp      = (x_in > MAX_X_C) ? MAX_X_C : x_in;
    assign y_clamp      = (y_in > MAX_Y_C) ? MAX_Y_C : y_in;
    assign x_diff       = calc_t'(x1_q) - calc_t'(x0_q);
    assign y_diff       = calc_t'(y1_q) - calc_t'(y0_q);
    assign dx_abs       = abs_calc(x_diff);
    assign dy_neg       = -abs_calc(y_diff);

    line_stepper #(
        .X_WIDTH(X_WIDTH),
        .Y_WIDTH(Y_WIDTH)
    ) u_stepper (
        .x_i     (px_x_q),
        .y_i     (px_y_q),
        .err_i   (err_q),
        .dx_i    (dx_q),
        .dy_i    (dy_q),
        .sx_neg_i(sx_neg_q),
        .sy_neg_i(sy_neg_q),
        .x_o     (step_x),
        .y_o     (step_y),
        .err_o   (step_err)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case infers a latch.
        state_d        = state_q;
        anchor_x_d     = anchor_x_q;
        anchor_y_d     = anchor_y_q;
        anchor_valid_d = anchor_valid_q;
        x0_d           = x0_q;
        y0_d           = y0_q;
        x1_d           = x1_q;
        y1_d           = y1_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        err_d          = err_q;
        sx_neg_d       = sx_neg_q;
        sy_neg_d       = sy_neg_q;
        px_valid_d     = px_valid_q;
        px_x_d         = px_x_q;
        px_y_d         = px_y_q;
        color_d        = color_q;
        sw_d           = sw_q;
        seg_done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    color_d        = color_in;
                    sw_d           = sw_in;
                    anchor_x_d     = x_clamp;
                    anchor_y_d     = y_clamp;
                    anchor_valid_d = 1'b1;
                    if (pen_down_in) begin
                        // Without a prior anchor the segment collapses to its end point.
                        x0_d    = anchor_valid_q ? anchor_x_q : x_clamp;
                        y0_d    = anchor_valid_q ? anchor_y_q : y_clamp;
                        x1_d    = x_clamp;
                        y1_d    = y_clamp;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                dx_d       = dx_abs;
                dy_d       = dy_neg;
                err_d      = dx_abs + dy_neg;
                sx_neg_d   = x_diff[CALC_W-1];
                sy_neg_d   = y_diff[CALC_W-1];
                px_x_d     = x0_q;
                px_y_d     = y0_q;
                px_valid_d = 1'b1;
                state_d    = STEP;
            end
            STEP: begin
                if (px_fire) begin
                    if (at_end) begin
                        px_valid_d = 1'b0;
                        seg_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        px_x_d = step_x;
                        px_y_d = step_y;
                        err_d  = step_err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            anchor_x_q     <= '0;
            anchor_y_q     <= '0;
            anchor_valid_q <= 1'b0;
            x0_q           <= '0;
            y0_q           <= '0;
            x1_q           <= '0;
            y1_q           <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            err_q          <= '0;
            sx_neg_q       <= 1'b0;
            sy_neg_q       <= 1'b0;
            px_valid_q     <= 1'b0;
            px_x_q         <= '0;
            px_y_q         <= '0;
            color_q        <= '0;
            sw_q           <= '0;
            seg_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            anchor_x_q     <= anchor_x_d;
            anchor_y_q     <= anchor_y_d;
            anchor_valid_q <= anchor_valid_d;
            x0_q           <= x0_d;
            y0_q           <= y0_d;
            x1_q           <= x1_d;
            y1_q           <= y1_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            err_q          <= err_d;
            sx_neg_q       <= sx_neg_d;
            sy_neg_q       <= sy_neg_d;
            px_valid_q     <= px_valid_d;
            px_x_q         <= px_x_d;
            px_y_q         <= px_y_d;
            color_q        <= color_d;
            sw_q           <= sw_d;
            seg_done_q     <= seg_done_d;
        end
    end

    assign px_valid_out = px_valid_q;
    assign px_x_out     = px_x_q;
    assign px_y_out     = px_y_q;
    assign px_color_out = color_q;
    assign px_sw_out    = sw_q;
    assign seg_done_out = seg_done_q;

endmodule

// File: tb/tb_stroke_interp.sv
// Directed bench for stroke_interp: hand-computed Bresenham pixel lists,
// handshake timing, backpressure, clamping, attribute latching and reset abort.
module tb_stroke_interp;
    import stroke_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       pt_valid_in;
    logic       pt_ready_out;
    canvas_x_t  x_in;
    canvas_y_t  y_in;
    logic [3:0] color_in;
    logic [2:0] sw_in;
    logic       pen_down_in;
    logic       px_valid_out;
    logic       px_ready_in;
    canvas_x_t  px_x_out;
    canvas_y_t  px_y_out;
    logic [3:0] px_color_out;
    logic [2:0] px_sw_out;
    logic       seg_done_out;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_x[$];
    int exp_y[$];

    always #5 clk_in = ~clk_in;

    stroke_interp dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .pt_valid_in (pt_valid_in),
        .pt_ready_out(pt_ready_out),
        .x_in        (x_in),
        .y_in        (y_in),
        .color_in    (color_in),
        .sw_in       (sw_in),
        .pen_down_in (pen_down_in),
        .px_valid_out(px_valid_out),
        .px_ready_in (px_ready_in),
        .px_x_out    (px_x_out),
        .px_y_out    (px_y_out),
        .px_color_out(px_color_out),
        .px_sw_out   (px_sw_out),
        .seg_done_out(seg_done_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_px(input int x, input int y);
        exp_x.push_back(x);
        exp_y.push_back(y);
    endtask

    task automatic send_point(input int x, input int y, input logic [3:0] c,
                              input logic [2:0] w, input logic pen);
        logic ready_seen;
        @(negedge clk_in);
        x_in        = 10'(x);
        y_in        = 9'(y);
        color_in    = c;
        sw_in       = w;
        pen_down_in = pen;
        pt_valid_in = 1'b1;
        ready_seen  = pt_ready_out;
        for (int k = 0; k < 50 && !ready_seen; k++) begin
            @(negedge clk_in);
            ready_seen = pt_ready_out;
        end
        if (!ready_seen) check("pt_ready_timeout", 0, 1);
        @(posedge clk_in);
        #1 pt_valid_in = 1'b0;
    endtask

    // Runs one segment: negedge k=1 is the SETUP cycle after acceptance.
    task automatic collect(input string name, input int stall_at, input int stall_len,
                           input logic [3:0] exp_c, input logic [2:0] exp_w,
                           input logic chg_attr);
        int n_pix, first_k, done_k, stall_cnt, held;
        n_pix = 0; first_k = -1; done_k = -1; stall_cnt = 0; held = 0;
        for (int k = 1; k <= 200 && done_k < 0; k++) begin
            @(negedge clk_in);
            if (seg_done_out) begin
                done_k = k;
            end else if (px_valid_out) begin
                if (first_k < 0) first_k = k;
                if (chg_attr) begin
                    color_in = ~exp_c;
                    sw_in    = ~exp_w;
                end
                if (n_pix == stall_at) held++;
                if (n_pix < exp_x.size()) begin
                    check({name, "_px_x"}, px_x_out, exp_x[n_pix]);
                    check({name, "_px_y"}, px_y_out, exp_y[n_pix]);
                end else begin
                    check({name, "_extra_px"}, 1, 0);
                end
                check({name, "_color"}, px_color_out, exp_c);
                check({name, "_sw"}, px_sw_out, exp_w);
                if (n_pix == stall_at && stall_cnt < stall_len) begin
                    px_ready_in = 1'b0;
                    stall_cnt++;
                end else begin
                    px_ready_in = 1'b1;
                    n_pix++;
                end
            end
        end
        px_ready_in = 1'b1;
        if (done_k < 0) begin
            check({name, "_done_timeout"}, 0, 1);
        end else begin
            check({name, "_pix_count"}, n_pix, exp_x.size());
            check({name, "_first_cycle"}, first_k, 2);
            check({name, "_done_cycle"}, done_k, exp_x.size() + 2 + stall_len);
            check({name, "_ready_at_done"}, pt_ready_out, 1);
            if (stall_len > 0) check({name, "_held_cycles"}, held, stall_len + 1);
            @(negedge clk_in);
            check({name, "_done_pulse_end"}, seg_done_out, 0);
            check({name, "_valid_after"}, px_valid_out, 0);
        end
        exp_x.delete();
        exp_y.delete();
    endtask

    initial begin
        rst_in      = 1'b1;
        pt_valid_in = 1'b0;
        x_in        = '0;
        y_in        = '0;
        color_in    = '0;
        sw_in       = '0;
        pen_down_in = 1'b0;
        px_ready_in = 1'b1;

        repeat (3) @(negedge clk_in);
        check("rst_px_valid", px_valid_out, 0);
        check("rst_px_x", px_x_out, 0);
        check("rst_px_y", px_y_out, 0);
        check("rst_color", px_color_out, 0);
        check("rst_sw", px_sw_out, 0);
        check("rst_seg_done", seg_done_out, 0);
        check("rst_pt_ready", pt_ready_out, 1);
        rst_in = 1'b0;

        // Clamp plus first point with no anchor, then a zero-length repeat.
        send_point(700, 400, 4'd5, 3'd2, 1'b1);
        expect_px(639, 359);
        collect("clamp", -1, 0, 4'd5, 3'd2, 1'b0);
        send_point(639, 359, 4'd6, 3'd3, 1'b1);
        expect_px(639, 359);
        collect("zero_len", -1, 0, 4'd6, 3'd3, 1'b0);

        // Shallow line; pen-up move must not emit anything.
        send_point(10, 10, 4'd1, 3'd1, 1'b0);
        @(negedge clk_in);
        check("penup_ready", pt_ready_out, 1);
        check("penup_valid", px_valid_out, 0);
        send_point(13, 11, 4'd3, 3'd1, 1'b1);
        expect_px(10, 10); expect_px(11, 10); expect_px(12, 11); expect_px(13, 11);
        collect("shallow", -1, 0, 4'd3, 3'd1, 1'b0);

        // Same line, downstream stalls 3 cycles on the second pixel.
        send_point(10, 10, 4'd2, 3'd4, 1'b0);
        send_point(13, 11, 4'd7, 3'd5, 1'b1);
        expect_px(10, 10); expect_px(11, 10); expect_px(12, 11); expect_px(13, 11);
        collect("bp", 1, 3, 4'd7, 3'd5, 1'b0);

        // Steep negative-y line.
        send_point(5, 5, 4'd0, 3'd0, 1'b0);
        send_point(5, 2, 4'd4, 3'd6, 1'b1);
        expect_px(5, 5); expect_px(5, 4); expect_px(5, 3); expect_px(5, 2);
        collect("steep", -1, 0, 4'd4, 3'd6, 1'b0);

        // Negative-x diagonal while colour/width inputs change mid-segment.
        send_point(3, 0, 4'd0, 3'd0, 1'b0);
        send_point(0, 3, 4'd9, 3'd6, 1'b1);
        expect_px(3, 0); expect_px(2, 1); expect_px(1, 2); expect_px(0, 3);
        collect("attr_diag", -1, 0, 4'd9, 3'd6, 1'b1);

        // Reset in the middle of a long horizontal segment.
        send_point(0, 0, 4'd1, 3'd1, 1'b0);
        send_point(100, 0, 4'd1, 3'd1, 1'b1);
        repeat (6) @(negedge clk_in);
        check("mid_valid", px_valid_out, 1);
        #1 rst_in = 1'b1;
        #1;
        check("abort_valid", px_valid_out, 0);
        check("abort_ready", pt_ready_out, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        send_point(50, 50, 4'd8, 3'd7, 1'b1);
        expect_px(50, 50);
        collect("after_rst", -1, 0, 4'd8, 3'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
